// File: rtl/ism_pkg.sv
// Shared constants for the instruction store: geometry, loader state encoding and byte-lane order.
// Imported by the loader, its interface and the fetch-side byte RAM.
package ism_pkg;

  localparam int ISM_DEPTH          = 512;
  localparam int ISM_AW             = 9;
  localparam int ISM_BYTES_PER_WORD = 4;

  // Big-endian packing: byte at PC+i carries word bits [31-8*i -: 8], so fetch
  // reassembles {M[PC], M[PC+1], M[PC+2], M[PC+3]} most-significant first.
  localparam bit ISM_BIG_ENDIAN = 1'b1;

  typedef logic [2:0] ism_state_t;

  localparam ism_state_t ISM_ST_IDLE   = 3'd0;
  localparam ism_state_t ISM_ST_ACCEPT = 3'd1;
  localparam ism_state_t ISM_ST_WRITE  = 3'd2;
  localparam ism_state_t ISM_ST_DONE   = 3'd3;
  localparam ism_state_t ISM_ST_ERR    = 3'd4;

endpackage

// File: rtl/ism_loader_if.sv
// Host word handshake, session control/status and byte write port of the instruction loader.
// master = boot/test host side, slave = loader side.
interface ism_loader_if #(
  parameter int AW = ism_pkg::ISM_AW
) ();

  logic          start;
  logic [AW-1:0] base_addr;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          word_last;
  logic          word_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic          overflow;

  modport master (
    output start, base_addr, word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow
  );

  modport slave (
    input  start, base_addr, word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow
  );

endinterface

// File: rtl/is_byte_ram.sv
// Byte-addressed instruction memory: synchronous byte write, combinational 4-byte big-endian fetch.
// Fetch addresses wrap modulo DEPTH.
module is_byte_ram
  import ism_pkg::*;
#(
  parameter int DEPTH = ISM_DEPTH,
  parameter int AW    = ISM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Lowest address shifted in first so it ends up in the top byte.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < ISM_BYTES_PER_WORD; i++) begin
      rdata = {rdata[23:0], mem[raddr + AW'(i)]};
    end
  end

endmodule

// File: rtl/ism_loader.sv
// Loads 32-bit words from a valid/ready host into byte memory, big-endian, one byte per cycle.
// 5 cycles per word (handshake + 4 writes); word_ready is low while writing and outside a session.
module ism_loader
  import ism_pkg::*;
#(
  parameter int DEPTH = ISM_DEPTH,
  parameter int AW    = ISM_AW
) (
  input  logic        CLK,
  input  logic        Reset,
  ism_loader_if.slave bus
);

  localparam logic [AW:0] END_ADDR = (AW+1)'(DEPTH);
  localparam logic [1:0]  LAST_IDX = 2'(ISM_BYTES_PER_WORD - 1);

  ism_state_t    state_q, state_d;
  logic [AW:0]   addr_q, addr_d, addr_inc;
  logic [31:0]   shift_q, shift_d;
  logic          last_q, last_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] base_aligned;

  logic          word_ready, mem_we, busy, done, overflow;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  assign addr_inc     = addr_q + (AW+1)'(1);
  assign base_aligned = bus.base_addr & ~AW'(3);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ISM_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISM_ST_IDLE, ISM_ST_DONE, ISM_ST_ERR: begin
        if (bus.start) state_d = ISM_ST_ACCEPT;
      end
      ISM_ST_ACCEPT: begin
        if (bus.word_valid) state_d = ISM_ST_WRITE;
      end
      ISM_ST_WRITE: begin
        // last wins over overflow so a final word ending at DEPTH-1 completes normally
        if (idx_q == LAST_IDX) begin
          if (last_q)                    state_d = ISM_ST_DONE;
          else if (addr_inc == END_ADDR) state_d = ISM_ST_ERR;
          else                           state_d = ISM_ST_ACCEPT;
        end
      end
      default: state_d = ISM_ST_IDLE;
    endcase
  end

  always_comb begin
    word_ready = (state_q == ISM_ST_ACCEPT);
    mem_we     = (state_q == ISM_ST_WRITE);
    busy       = (state_q == ISM_ST_ACCEPT) || (state_q == ISM_ST_WRITE);
    done       = (state_q == ISM_ST_DONE);
    overflow   = (state_q == ISM_ST_ERR);
    mem_addr   = addr_q[AW-1:0];
    mem_wdata  = shift_q[31:24];
  end

  always_comb begin
    addr_d  = addr_q;
    shift_d = shift_q;
    last_d  = last_q;
    idx_d   = idx_q;
    case (state_q)
      ISM_ST_IDLE, ISM_ST_DONE, ISM_ST_ERR: begin
        if (bus.start) addr_d = {1'b0, base_aligned};
      end
      ISM_ST_ACCEPT: begin
        if (bus.word_valid) begin
          shift_d = bus.word_data;
          last_d  = bus.word_last;
          idx_d   = 2'd0;
        end
      end
      ISM_ST_WRITE: begin
        shift_d = {shift_q[23:0], 8'h00};
        addr_d  = addr_inc;
        idx_d   = idx_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      addr_q  <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      addr_q  <= addr_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.word_ready = word_ready;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.overflow   = overflow;

endmodule

// File: tb/tb_ism_loader.sv
// Bench for ism_loader: directed table, hand-written corner sequences and random sessions
// against a byte-array memory model; readback goes through the fetch view of is_byte_ram.
module tb_ism_loader;
  import ism_pkg::*;

  localparam int DEPTH = ISM_DEPTH;
  localparam int AW    = ISM_AW;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  ism_loader_if #(.AW(AW)) bus ();

  ism_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  logic [AW-1:0] pc;
  logic [31:0]   fetch;

  is_byte_ram #(.DEPTH(DEPTH), .AW(AW)) ram (
    .clk  (CLK),
    .we   (bus.mem_we),
    .waddr(bus.mem_addr),
    .wdata(bus.mem_wdata),
    .raddr(pc),
    .rdata(fetch)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Observed byte writes and ready cycles, sampled away from the clock edge.
  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t cap[$];
  int  rdy_cnt = 0;

  always @(negedge CLK) begin
    if (bus.mem_we === 1'b1) cap.push_back('{int'(bus.mem_addr), int'(bus.mem_wdata), cyc});
    if (bus.word_ready === 1'b1) rdy_cnt++;
  end

  // Reference model: memory image plus the expected write sequence of one session.
  logic [7:0] mdl_mem   [DEPTH];
  bit         mdl_known [DEPTH];
  typedef struct { int addr; int data; int word; int lane; } exp_t;
  exp_t expq[$];

  task automatic model_session(input int base, input logic [31:0] words[$], input bit lasts[$],
                               output int n_acc, output bit e_done, output bit e_ovf);
    int a;
    a = base - (base % 4);
    n_acc = 0; e_done = 0; e_ovf = 0;
    expq.delete();
    for (int w = 0; w < words.size(); w++) begin
      for (int k = 0; k < 4; k++) begin
        int b;
        b = int'((words[w] >> (8 * (3 - k))) & 32'hFF);
        expq.push_back('{a + k, b, w, k});
        mdl_mem[a + k]   = 8'(b);
        mdl_known[a + k] = 1'b1;
      end
      a += 4;
      n_acc++;
      if (lasts[w]) begin e_done = 1; break; end
      if (a == DEPTH) begin e_ovf = 1; break; end
    end
  endtask

  task automatic start_session(input int base);
    @(negedge CLK);
    cap.delete();
    rdy_cnt = 0;
    bus.start = 1'b1;
    bus.base_addr = AW'(base);
    @(negedge CLK);
    bus.start = 1'b0;
    check("start clears done", bus.done, 0);
    check("start clears overflow", bus.overflow, 0);
    check("start busy", bus.busy, 1);
  endtask

  task automatic send_word(input string nm, input logic [31:0] w, input bit l, input int gap,
                           output int hs_cyc);
    int n = 0;
    bus.word_valid = 1'b0;
    while (bus.word_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check({nm, " ready for word"}, bus.word_ready, 1);
    repeat (gap) @(negedge CLK);
    bus.word_valid = 1'b1;
    bus.word_data  = w;
    bus.word_last  = l;
    hs_cyc = cyc;
    @(negedge CLK);
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
  endtask

  task automatic run_session(input string nm, input int base, input logic [31:0] words[$],
                             input bit lasts[$], input int gaps[$], input bit inj_start);
    int n_acc, h, gsum, a0, n;
    bit e_done, e_ovf;
    int hs[$];
    gsum = 0;
    model_session(base, words, lasts, n_acc, e_done, e_ovf);
    start_session(base);
    for (int w = 0; w < n_acc; w++) begin
      send_word(nm, words[w], lasts[w], gaps[w], h);
      hs.push_back(h);
      gsum += gaps[w];
      if (w > 0) check({nm, " word period"}, h - hs[w-1], 5 + gaps[w]);
      if (inj_start && w == 0) begin
        bus.start = 1'b1;
        bus.base_addr = '0;
        @(negedge CLK);
        bus.start = 1'b0;
      end
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check({nm, " busy end"}, bus.busy, 0);
    check({nm, " end cycle"}, cyc, hs[hs.size()-1] + 5);
    check({nm, " done"}, bus.done, e_done);
    check({nm, " overflow"}, bus.overflow, e_ovf);
    check({nm, " ready end"}, bus.word_ready, 0);
    check({nm, " we end"}, bus.mem_we, 0);
    check({nm, " ready cycles"}, rdy_cnt, n_acc + gsum);
    check({nm, " write count"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++) begin
      check({nm, " wr addr"}, cap[i].addr, expq[i].addr);
      check({nm, " wr data"}, cap[i].data, expq[i].data);
      check({nm, " wr cycle"}, cap[i].cyc, hs[expq[i].word] + 1 + expq[i].lane);
    end
    a0 = base - (base % 4);
    for (int w = 0; w < n_acc; w++) begin
      pc = AW'(a0 + 4 * w);
      #1;
      check({nm, " fetch"}, fetch, words[w]);
    end
  endtask

  typedef struct {
    int          base;
    logic [31:0] word;
    bit          last;
    int          gap;
    bit          exp_done;
    bit          exp_ovf;
    int          exp_a0;
  } vec_t;

  vec_t        vt[5];
  logic [31:0] wq[$];
  bit          lq[$];
  int          gq[$];
  int          h;

  initial begin
    vt[0] = '{32'h000, 32'h8C010004, 1'b1, 0, 1'b1, 1'b0, 32'h000};
    vt[1] = '{32'h0A5, 32'h12345678, 1'b1, 7, 1'b1, 1'b0, 32'h0A4};
    vt[2] = '{32'h1FC, 32'hDEADBEEF, 1'b0, 0, 1'b0, 1'b1, 32'h1FC};
    vt[3] = '{32'h000, 32'h00000013, 1'b1, 2, 1'b1, 1'b0, 32'h000};
    vt[4] = '{32'h1FE, 32'hCAFEF00D, 1'b1, 1, 1'b1, 1'b0, 32'h1FC};

    bus.start = 1'b0; bus.base_addr = '0; bus.word_valid = 1'b0;
    bus.word_data = '0; bus.word_last = 1'b0; pc = '0;
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset word_ready", bus.word_ready, 0);
    check("reset mem_we", bus.mem_we, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset mem_wdata", bus.mem_wdata, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset overflow", bus.overflow, 0);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      wq = '{vt[i].word}; lq = '{vt[i].last}; gq = '{vt[i].gap};
      run_session("table", vt[i].base, wq, lq, gq, 1'b0);
      check("table done", bus.done, vt[i].exp_done);
      check("table overflow", bus.overflow, vt[i].exp_ovf);
      check("table first addr", (cap.size() > 0) ? cap[0].addr : -1, vt[i].exp_a0);
    end

    wq = '{32'h20010001, 32'h20020002, 32'hAC020000}; lq = '{0, 0, 1}; gq = '{0, 0, 0};
    run_session("stream", 32'h010, wq, lq, gq, 1'b0);
    check("stream last addr", (cap.size() == 12) ? cap[11].addr : -1, 32'h01B);

    wq = '{32'h0F1E2D3C, 32'h55AA33CC}; lq = '{0, 1}; gq = '{0, 0};
    run_session("ignored start", 32'h080, wq, lq, gq, 1'b1);

    // Reset lands while byte 1 is on the write port.
    start_session(32'h040);
    send_word("reset mid", 32'hA1B2C3D4, 1'b1, 0, h);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    check("rst mid mem_we", bus.mem_we, 0);
    check("rst mid word_ready", bus.word_ready, 0);
    check("rst mid busy", bus.busy, 0);
    check("rst mid done", bus.done, 0);
    check("rst mid overflow", bus.overflow, 0);
    check("rst mid mem_addr", bus.mem_addr, 0);
    check("rst mid mem_wdata", bus.mem_wdata, 0);
    check("rst mid write count", cap.size(), 2);
    check("rst mid byte1 addr", (cap.size() >= 2) ? cap[1].addr : -1, 32'h041);
    check("rst mid byte1 data", (cap.size() >= 2) ? cap[1].data : -1, 32'hB2);
    Reset = 1'b0;
    mdl_mem[32'h040] = 8'hA1; mdl_known[32'h040] = 1'b1;
    mdl_mem[32'h041] = 8'hB2; mdl_known[32'h041] = 1'b1;
    pc = AW'(32'h040);
    #1;
    check("rst mid fetch hi", fetch[31:16], 16'hA1B2);

    for (int s = 0; s < 25; s++) begin
      int base, nw;
      base = ($urandom_range(0, 2) == 0) ? $urandom_range(DEPTH - 16, DEPTH - 1)
                                         : $urandom_range(0, DEPTH - 1);
      nw = $urandom_range(1, 4);
      wq.delete(); lq.delete(); gq.delete();
      for (int w = 0; w < nw; w++) begin
        wq.push_back($urandom);
        lq.push_back(w == nw - 1);
        gq.push_back($urandom_range(0, 3));
      end
      run_session("random", base, wq, lq, gq, 1'b0);
    end

    for (int r = 0; r < 10; r++) begin
      int p;
      bit ok;
      ok = 1'b0;
      p = 0;
      for (int t = 0; t < 300 && !ok; t++) begin
        p = $urandom_range(0, DEPTH - 1);
        ok = mdl_known[p] && mdl_known[(p + 1) % DEPTH] &&
             mdl_known[(p + 2) % DEPTH] && mdl_known[(p + 3) % DEPTH];
      end
      if (ok) begin
        pc = AW'(p);
        #1;
        check("random fetch", fetch, {mdl_mem[p], mdl_mem[(p + 1) % DEPTH],
                                      mdl_mem[(p + 2) % DEPTH], mdl_mem[(p + 3) % DEPTH]});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ism_loader.md
Name: ism_loader

Overview:
- Write-side counterpart of the instruction store. Accepts 32-bit instruction words over a valid/ready handshake and writes them big-endian, one byte per cycle, into the 512-byte byte-addressed instruction memory.
- The instruction fetch path later reads the same bytes as {M[PC], M[PC+1], M[PC+2], M[PC+3]}.
- Sits between the test/boot host and the instruction memory write port. Used to load programs at runtime instead of from an init file.

Parameters:
- DEPTH, 512, instruction memory size in bytes.
- AW, 9, byte address width; must equal log2(DEPTH).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load session at base_addr.
- base_addr  in  AW  first byte address; bits [1:0] are ignored and treated as 0.
- word_valid  in  1  host has a word on word_data.
- word_data  in  32  instruction word.
- word_last  in  1  qualifies word_data as the final word of the session.
- word_ready  out  1  loader can accept a word this cycle.
- mem_we  out  1  byte write enable to the instruction memory.
- mem_addr  out  AW  byte write address.
- mem_wdata  out  8  byte write data.
- busy  out  1  session in progress (ACCEPT or WRITE).
- done  out  1  session finished normally; held until next start or Reset.
- overflow  out  1  session aborted because the memory end was reached; held until next start or Reset.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high.
- Reset values: state=IDLE, addr counter=0, word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0.
- All outputs decode from flops only; there is no combinational input-to-output path.
- Addr counter is AW+1 bits wide so that DEPTH is representable.

State machine: IDLE, ACCEPT, WRITE, DONE, ERR.
- IDLE / DONE / ERR + start=1 -> ACCEPT.
  - addr counter <= {base_addr[AW-1:2], 2'b00}.
  - done and overflow clear.
- ACCEPT:
  - word_ready=1.
  - On word_valid & word_ready: latch word_data into a shift register, latch word_last, clear byte index, go to WRITE.
  - word_valid=0 -> stay in ACCEPT indefinitely; there is no timeout.
- WRITE, 4 cycles, byte index 0..3:
  - mem_we=1, mem_addr=addr[AW-1:0].
  - mem_wdata = shift[31:24], so byte0 = word[31:24] (big-endian).
  - Each cycle: shift left by 8, addr += 1.
  - After byte 3:
    - word_last=1 -> DONE.
    - else addr==DEPTH -> ERR.
    - else -> ACCEPT.
- DONE: done=1. ERR: overflow=1. In both, word_ready=0.
- start is ignored while in ACCEPT or WRITE.
- Throughput is 5 cycles per word (1 handshake + 4 writes). word_ready=0 throughout WRITE.
- A final word whose last byte lands at DEPTH-1 with word_last=1 ends in DONE, not ERR.
- Reset mid-WRITE: mem_we is 0 from the next cycle. Bytes already written stay written; there is no rollback.
- mem_we is never asserted outside WRITE.

Decomposition:
- Shared package ism_pkg holds:
  - ISM_DEPTH=512 and ISM_AW=9.
  - State encoding localparams (IDLE=0, ACCEPT=1, WRITE=2, DONE=3, ERR=4; 3-bit).
  - Byte-lane ordering constant documenting big-endian packing, shared with the fetch side.
- No RTL sub-module is natural; the block is a single FSM plus datapath.
- The bench instantiates a byte RAM model, is_byte_ram, with a synchronous write port and the existing 4-byte combinational read, to check reads back through the fetch view.

Test Plan:
- Single word: start with base_addr=0; word 0x8C010004 with last=1.
  -> Writes 0x8C@0, 0x01@1, 0x00@2, 0x04@3 on 4 consecutive cycles after the handshake.
  -> done=1 on the 5th cycle.
  -> Fetch view at PC=0 reads 0x8C010004.
- Back-to-back stream: base_addr=0x010; words 0x20010001, 0x20020002, 0xAC020000 with last on the third.
  -> 12 byte writes to addresses 0x010..0x01B.
  -> word_ready high exactly once every 5 cycles.
  -> done after the final byte.
- Backpressure and misalignment: base_addr=0x0A5; word_valid held low 7 cycles, then 0x12345678 with last=1.
  -> Loader stays in ACCEPT with word_ready=1 while waiting.
  -> Writes 0x12@0x0A4 .. 0x78@0x0A7.
- Overflow: base_addr=0x1FC; word 0xDEADBEEF with last=0.
  -> Writes 0x1FC..0x1FF, then overflow=1, busy=0, word_ready=0.
  -> A second start with base 0 clears overflow.
- Exact end with last: base_addr=0x1FC; word with last=1.
  -> done=1, overflow=0.
- Reset and ignored start: Reset asserted during WRITE after byte 1.
  -> Only bytes 0 and 1 written; next cycle mem_we=0 and all outputs at reset values.
  -> Separately, start pulsed during WRITE is ignored: addresses continue sequentially.
